sum_stream_accumulator: RTL
===========================

// Module: sum_stream_accumulator
//
// PURPOSE
//   Downstream consumer of the a+b sum stream. Accepts sum beats over a
//   valid/ready handshake and adds up each group of n consecutive beats.
//   Each group total goes out on a second valid/ready stream through a
//   2-entry output buffer, so upstream keeps flowing while one result stalls.
//
// PARAMETERS
//   width  4  bits per incoming sum beat
//   n      4  beats per group (n >= 1)
//   Derived: ow = width + $clog2(n) (result width);
//            cw = $clog2(n + 1) (beat-count width)
//
// PORTS
//   clk        in   1      clock
//   rst        in   1      reset, asynchronous, active-high
//   sum_valid  in   1      upstream beat valid
//   sum_ready  out  1      upstream beat ready
//   sum_data   in   width  upstream beat, unsigned
//   acc_valid  out  1      group result valid
//   acc_ready  in   1      group result ready
//   acc_data   out  ow     group total, unsigned, never wraps
//   acc_count  out  cw     number of beats in this result
//   flush      in   1      close partial group (only with SUM_ACC_FLUSH_EN)
//
// BEHAVIOUR
//   - Transfer happens on any edge where valid & ready.
//   - State: running total acc_r [ow], beat counter cnt_r 0..n-1,
//     2-entry output FIFO (rd/wr pointers, occupancy 0..2).
//   - Reset (async, immediate): acc_r=0, cnt_r=0, FIFO empty,
//     acc_valid=0, acc_data=0, acc_count=0.
//   - sum_ready = (occupancy != 2). It is combinational from registers only
//     and is therefore 1 during and after reset. Upstream ignores transfers
//     while rst=1.
//   - acc_valid = (occupancy != 0). acc_data and acc_count show the FIFO
//     head; they stay stable while acc_valid & ~acc_ready.
//   - Accepted beat with cnt_r < n-1: acc_r += sum_data, cnt_r++.
//   - Accepted beat with cnt_r == n-1:
//     - push {acc_r + sum_data, n} into the FIFO;
//     - clear acc_r and cnt_r to 0 on the same edge.
//   - Latency: acc_valid rises the cycle after the n-th beat transfer.
//     Throughput: one beat per cycle while the FIFO is not full.
//   - Push and pop on the same edge (occupancy 1): occupancy stays 1,
//     data order is preserved. Pop only: occupancy--. Push only: occupancy++.
//   - Occupancy 2: sum_ready=0, no beats accepted, partial group held.
//     A pop re-opens sum_ready on the next cycle.
//   - n=1: every beat becomes one result of count 1.
//   - Arithmetic is zero-extended and needs no overflow handling, since
//     n * (2^width - 1) < 2^ow.
//
// CONFIGURATION
//   SUM_ACC_FLUSH_EN defined:
//     - flush port exists. flush is honoured only when sum_ready=1;
//       otherwise the source holds it until it is honoured.
//     - If honoured and the group is non-empty, the group closes and pushes
//       {total, beats}. The group includes a beat transferred on the same
//       edge, and beats is in 1..n.
//     - Empty group (cnt_r=0, no beat this edge): flush is a no-op.
//     - flush on an edge that completes n beats anyway: a single result
//       with count n.
//   SUM_ACC_FLUSH_EN undefined:
//     - flush port absent; acc_count is always n.
//
// TESTING  (width=4, n=4 unless noted)
//   1. acc_ready=1, beats 1..8 back-to-back:
//      acc 10/cnt 4 the cycle after beat 4, 26/cnt 4 after beat 8;
//      sum_ready stays 1.
//   2. Four beats of 0xF: acc_data=0x3C (60), no wrap at ow=6.
//   3. acc_ready=0, 12 beats offered: sum_ready drops after beat 8 is
//      accepted. Then set acc_ready=1: outputs 10, 26 in order, then beats
//      9..12 accepted, then 42.
//   4. Two beats accepted, rst pulsed mid-cycle: acc_valid=0 immediately.
//      Next beats 1,1,1,1 -> 4 (no stale partial sum).
//   5. SUM_ACC_FLUSH_EN: beats 3,5 with flush on beat 5 -> 8/cnt 2.
//      flush on an empty group -> no output. flush with sum_ready=0 -> held,
//      then honoured.
//   6. Random valid/ready both sides, 100 groups against a queue model;
//      final queue empty.

Source files
------------

// File: rtl/sum_stream_accumulator.sv
// sum_stream_accumulator
//   Adds up each group of n consecutive sum beats taken over a valid/ready
//   handshake. Each group total, with its beat count, leaves through a
//   2-entry output FIFO, so the upstream side keeps flowing while one result
//   waits downstream.
//   Optional feature: define SUM_ACC_FLUSH_EN to add the flush input, which
//   closes a partial group early. Without it, acc_count always reads n.
module sum_stream_accumulator #(
    parameter int width = 4,
    parameter int n     = 4,
    localparam int ow   = width + $clog2(n),
    localparam int cw   = $clog2(n + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sum_valid,
    output logic             sum_ready,
    input  logic [width-1:0] sum_data,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic [ow-1:0]    acc_data,
    output logic [cw-1:0]    acc_count
`ifdef SUM_ACC_FLUSH_EN
    ,
    input  logic             flush
`endif
);

    // Running group state
    logic [ow-1:0] acc_r;
    logic [cw-1:0] cnt_r;

    // Two-entry result FIFO
    logic [ow-1:0] fifo_data  [2];
    logic [cw-1:0] fifo_count [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    occ;

    // Per-edge decisions
    logic          beat;
    logic          pop;
    logic          flush_req;
    logic          close;
    logic [ow-1:0] total_next;
    logic [cw-1:0] count_next;

    // Handshake outputs come from registers only. The FIFO head is always
    // driven onto the result bus, so it holds steady while a result stalls.
    assign sum_ready = (occ != 2'd2);
    assign acc_valid = (occ != 2'd0);
    assign acc_data  = fifo_data[rd_ptr];
    assign acc_count = fifo_count[rd_ptr];

    // A flush counts only on an edge where upstream could also transfer.
`ifdef SUM_ACC_FLUSH_EN
    assign flush_req = flush & sum_ready;
`else
    assign flush_req = 1'b0;
`endif

    // Work out what this edge does: transfers, the group total including any
    // beat taken now, and whether the group closes.
    always_comb begin
        // NOTE: every signal gets a default first, so no path can leave one
        // unassigned and turn it into a latch.
        beat       = 1'b0;
        pop        = 1'b0;
        total_next = acc_r;
        count_next = cnt_r;
        close      = 1'b0;

        beat = sum_valid & sum_ready;
        pop  = acc_valid & acc_ready;
        if (beat) begin
            total_next = acc_r + ow'(sum_data);
            count_next = cnt_r + cw'(1);
        end
        // A group closes on its n-th beat, or on a flush when it holds at
        // least one beat (counting a beat taken on the same edge).
        close = (beat && (cnt_r == cw'(n - 1))) ||
                (flush_req && (count_next != '0));
    end

    // Accumulate beats into the running total. Closing a group clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: state registers use non-blocking assignments, so every
            // register updates from the values present before the edge.
            acc_r <= '0;
            cnt_r <= '0;
        end else if (close) begin
            acc_r <= '0;
            cnt_r <= '0;
        end else if (beat) begin
            acc_r <= total_next;
            cnt_r <= count_next;
        end
    end

    // Push closed groups into the FIFO and pop them on downstream transfers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the storage itself is reset, not only the pointers,
            // because it drives acc_data/acc_count directly and those must
            // read zero out of reset.
            for (int i = 0; i < 2; i++) begin
                fifo_data[i]  <= '0;
                fifo_count[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            // A push needs sum_ready, so the FIFO is never full here.
            if (close) begin
                fifo_data[wr_ptr]  <= total_next;
                fifo_count[wr_ptr] <= count_next;
                wr_ptr             <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({close, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

endmodule
